// File: rtl/sad_best_match_tracker_if.sv
// Candidate/result bundle between the EX-stage SAD payload producer and the
// best-match tracker; the producer side uses master, the tracker uses slave.
interface sad_best_match_tracker_if #(
  parameter int NPIX   = 16,
  parameter int DATA_W = 32,
  parameter int SAD_W  = 32
);
  logic                   Start;
  logic                   In_Valid;
  logic                   In_Last;
  logic [31:0]            Pos_X;
  logic [31:0]            Pos_Y;
  logic [NPIX*DATA_W-1:0] Window_Data;
  logic [NPIX*DATA_W-1:0] Template_Data;
  logic                   Busy;
  logic                   Cand_Valid;
  logic [SAD_W-1:0]       Cand_SAD;
  logic [SAD_W-1:0]       Best_SAD;
  logic [31:0]            Best_X;
  logic [31:0]            Best_Y;
  logic                   Done;

  modport master (
    output Start, In_Valid, In_Last, Pos_X, Pos_Y, Window_Data, Template_Data,
    input  Busy, Cand_Valid, Cand_SAD, Best_SAD, Best_X, Best_Y, Done
  );

  modport slave (
    input  Start, In_Valid, In_Last, Pos_X, Pos_Y, Window_Data, Template_Data,
    output Busy, Cand_Valid, Cand_SAD, Best_SAD, Best_X, Best_Y, Done
  );
endinterface

// File: rtl/sad_best_match_tracker.sv
// Two-stage SAD pipeline over 4x4 candidate blocks with a running minimum
// tracker; pulses Done once the Last candidate of a search has been compared.
module sad_best_match_tracker #(
  parameter int NPIX   = 16,
  parameter int DATA_W = 32,
  parameter int SAD_W  = 32
) (
  input logic Clk,
  input logic Reset,
  sad_best_match_tracker_if.slave bus
);

  localparam int ROWS  = NPIX / 4;
  localparam int ROW_W = DATA_W + 2;
  localparam int TOT_W = ROW_W + $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;
  logic   accept;

  logic             s1_valid;
  logic [ROW_W-1:0] s1_row [ROWS];
  logic [31:0]      s1_x, s1_y;
  logic             s1_last;

  logic             cand_valid;
  logic [SAD_W-1:0] cand_sad;
  logic [31:0]      c_x, c_y;
  logic             c_last;

  logic [SAD_W-1:0] best_sad;
  logic [31:0]      best_x, best_y;

  logic [ROW_W-1:0] row_sum [ROWS];
  logic [TOT_W-1:0] total;
  logic [SAD_W-1:0] total_sat;

  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Start outranks any same-cycle candidate, so it is never accepted.
  assign accept = (state == RUN) && bus.In_Valid && !bus.Start;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      row_sum[r] = '0;
      for (int c = 0; c < 4; c++) begin
        row_sum[r] = row_sum[r] + ROW_W'(abs_diff(
          bus.Window_Data[(r*4+c)*DATA_W +: DATA_W],
          bus.Template_Data[(r*4+c)*DATA_W +: DATA_W]));
      end
    end
  end

  always_comb begin
    total = '0;
    for (int r = 0; r < ROWS; r++) begin
      total = total + TOT_W'(s1_row[r]);
    end
    total_sat = (|total[TOT_W-1:SAD_W]) ? '1 : total[SAD_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.Start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     if (accept && bus.In_Last) state_nxt = DRAIN;
        DRAIN:   if (cand_valid && c_last)  state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: stage-1 payload registers are not reset; only their valid bit
  // matters, and it is cleared by Reset and Start.
  always_ff @(posedge Clk) begin
    if (accept) begin
      s1_row  <= row_sum;
      s1_x    <= bus.Pos_X;
      s1_y    <= bus.Pos_Y;
      s1_last <= bus.In_Last;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid   <= 1'b0;
      cand_valid <= 1'b0;
      cand_sad   <= '0;
      c_x        <= '0;
      c_y        <= '0;
      c_last     <= 1'b0;
      best_sad   <= '0;
      best_x     <= '0;
      best_y     <= '0;
    end else begin
      s1_valid   <= accept;
      cand_valid <= s1_valid && !bus.Start;
      if (s1_valid) begin
        cand_sad <= total_sat;
        c_x      <= s1_x;
        c_y      <= s1_y;
        c_last   <= s1_last;
      end
      // Strict compare: ties and saturated SADs never displace the current best.
      if (bus.Start) begin
        best_sad <= '1;
        best_x   <= '0;
        best_y   <= '0;
      end else if (cand_valid && (cand_sad < best_sad)) begin
        best_sad <= cand_sad;
        best_x   <= c_x;
        best_y   <= c_y;
      end
    end
  end

  assign bus.Busy       = (state != IDLE);
  assign bus.Done       = (state == DONE);
  assign bus.Cand_Valid = cand_valid;
  assign bus.Cand_SAD   = cand_sad;
  assign bus.Best_SAD   = best_sad;
  assign bus.Best_X     = best_x;
  assign bus.Best_Y     = best_y;

endmodule
